beacon_sense_scheduler: RTL and testbench
=========================================

Name: beacon_sense_scheduler

Overview:
Sequences the beacon's shared ADC over three channels: capacitor voltage, PV power and supply rail. It qualifies each reading with thresholds, hysteresis and debounce, then drives the status flags consumed by the beacon power FSM: cap_charged, cap_over5, PV_power_high and low_power. It is the only ADC requester in the beacon. Thresholds are quasi-static configuration inputs.

Parameters:
ADC_W, 12, ADC sample width
SAMPLE_DIV, 1000, clk cycles between scan ticks (>=8)
DEBOUNCE, 4, consecutive agreeing samples needed to change a flag (1..15)
TIMEOUT, 255, max cycles waiting for adc_ack before abandoning a conversion

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
adc_req  out  1  conversion request, held until ack or timeout
adc_ch  out  2  channel select: 0 cap, 1 PV, 2 rail; stable while adc_req=1
adc_ack  in  1  one-cycle pulse, adc_data valid in same cycle
adc_data  in  ADC_W  conversion result
cap_full_th  in  ADC_W  cap_charged threshold
cap_5v_th  in  ADC_W  cap_over5 threshold
pv_high_th / pv_low_th  in  ADC_W  PV hysteresis upper/lower (high >= low)
rail_low_th / rail_ok_th  in  ADC_W  rail hysteresis lower/upper (ok >= low)
cap_charged, cap_over5, PV_power_high, low_power  out  1 each  qualified flags
scan_done  out  1  one-cycle pulse after the channel-2 evaluation completes
adc_timeout  out  1  sticky, set on any ack timeout, cleared only by reset

Behaviour:
- Reset values (async, immediate): adc_req=0, adc_ch=0, cap_charged=0, cap_over5=0, PV_power_high=0, low_power=1 (fail-safe: keeps the beacon idle until the rail is proven), scan_done=0, adc_timeout=0, all debounce counters=0, tick counter=0, FSM=WAIT_TICK.
- Tick counter is free-running modulo SAMPLE_DIV. tick=1 for one cycle when count==SAMPLE_DIV-1.
- FSM states:
  - WAIT_TICK: on tick go to REQ with ch=0. Ticks arriving in any other state are dropped, not queued.
  - REQ: adc_req=1, adc_ch=ch. Go to WAIT_ACK.
  - WAIT_ACK: adc_req stays 1.
    - If adc_ack=1: capture adc_data, drop adc_req next cycle, go to EVAL.
    - Else if wait count reaches TIMEOUT: drop adc_req, set adc_timeout, skip evaluation for this channel (flags and counters unchanged), go to NEXT.
  - EVAL: update the filter for ch, then go to NEXT.
  - NEXT: if ch==2, pulse scan_done and go to WAIT_TICK. Otherwise ch+1, go to REQ.
- adc_ack while adc_req=0 is ignored. adc_ack in the same cycle as the timeout expiry counts as an ack.
- Raw conditions (unsigned compares):
  - cap_charged: data >= cap_full_th.
  - cap_over5: data >= cap_5v_th.
  - PV_power_high: raw=1 if data >= pv_high_th, raw=0 if data < pv_low_th, else raw=current flag.
  - low_power: raw=1 if data < rail_low_th, raw=0 if data >= rail_ok_th, else raw=current flag.
- Channel 0 updates both cap filters from one sample.
- Debounce:
  - If raw != flag, counter+1. When counter reaches DEBOUNCE, toggle the flag and clear the counter.
  - If raw == flag, clear the counter.
  - The counter saturates and never wraps.
- Latency: ack at cycle N; EVAL at N+1; flag change visible at N+2.
- Threshold inputs are sampled only in EVAL; changing them mid-scan affects only later evaluations.
- Outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- beacon_pkg holds:
  - channel enum: CH_CAP=0, CH_PV=1, CH_RAIL=2
  - scanner state enum: WAIT_TICK, REQ, WAIT_ACK, EVAL, NEXT
  - reset-value constants for the four flags
- Sub-module beacon_flag_filter (params ADC_W, DEBOUNCE, RESET_VAL) implements the hysteresis compare and debounce counter. Inputs: en, data, set_th, clr_th, polarity. Instantiated four times.

Test Plan:
1. Reset with rst_n low mid-WAIT_ACK (adc_req=1) -> adc_req=0 and low_power=1 asynchronously; all other flags 0.
2. DEBOUNCE=4, ADC acks within 3 cycles, channel 0 returns 0xF00, cap_full_th=0xE00 -> cap_charged rises two cycles after the ack of the 4th scan, not the 3rd.
3. PV hysteresis with pv_high_th=0x800, pv_low_th=0x600: PV samples 0x900 x4 -> PV_power_high=1. Then 0x700 x6 -> stays 1. Then 0x500 x4 -> falls to 0.
4. Rail 0x100 with rail_low_th=0x200, alternating with 0x300 (rail_ok_th=0x280) every scan -> low_power never changes (counter clears).
5. TIMEOUT=16, no ack on channel 1 -> adc_req drops after 16 cycles, adc_timeout=1 sticky, PV_power_high unchanged. Channel 2 is still requested and scan_done pulses.
6. SAMPLE_DIV=64, ADC ack delay of 30 cycles -> missed ticks dropped, scans restart only on the first tick after scan_done, spurious adc_ack with adc_req=0 ignored.

Source files
------------

// File: rtl/beacon_pkg.sv
// Shared channel codes, scanner state codes and flag reset values for the beacon ADC scanner.
package beacon_pkg;

  typedef logic [1:0] ch_t;
  localparam ch_t CH_CAP  = 2'd0;
  localparam ch_t CH_PV   = 2'd1;
  localparam ch_t CH_RAIL = 2'd2;

  typedef logic [2:0] state_t;
  localparam state_t WAIT_TICK = 3'd0;
  localparam state_t REQ       = 3'd1;
  localparam state_t WAIT_ACK  = 3'd2;
  localparam state_t EVAL      = 3'd3;
  localparam state_t NEXT      = 3'd4;

  // low_power resets high so the beacon stays idle until the rail is proven good.
  localparam logic CAP_CHARGED_RST = 1'b0;
  localparam logic CAP_OVER5_RST   = 1'b0;
  localparam logic PV_HIGH_RST     = 1'b0;
  localparam logic LOW_POWER_RST   = 1'b1;

endpackage

// File: rtl/beacon_flag_filter.sv
// One qualified status flag: hysteresis compare of a sample followed by a debounce counter.
// polarity_i=0: raw=1 when data>=set_th, raw=0 when data<clr_th.
// polarity_i=1: raw=1 when data<set_th,  raw=0 when data>=clr_th.
// Between the two thresholds the raw condition follows the current flag.
module beacon_flag_filter #(
  parameter int unsigned ADC_W     = 12,
  parameter int unsigned DEBOUNCE  = 4,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic [ADC_W-1:0] data_i,
  input  logic [ADC_W-1:0] set_th_i,
  input  logic [ADC_W-1:0] clr_th_i,
  input  logic             polarity_i,
  output logic             flag_o
);

  localparam logic [3:0] DebLast = 4'(DEBOUNCE - 1);

  logic       flag_q, flag_d;
  logic [3:0] cnt_q, cnt_d;
  logic       raw;

  // Hysteresis compare producing the raw condition.
  always_comb begin
    raw = flag_q;
    if (!polarity_i) begin
      if (data_i >= set_th_i)     raw = 1'b1;
      else if (data_i < clr_th_i) raw = 1'b0;
    end else begin
      if (data_i < set_th_i)       raw = 1'b1;
      else if (data_i >= clr_th_i) raw = 1'b0;
    end
  end

  // Debounce: count disagreeing samples, toggle on the DEBOUNCE-th; any agreement clears.
  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (en_i) begin
      if (raw != flag_q) begin
        if (cnt_q >= DebLast) begin
          flag_d = ~flag_q;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  // Flag and counter state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= RESET_VAL;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flag_o = flag_q;

endmodule

// File: rtl/beacon_sense_scheduler.sv
// Scans the shared ADC over cap / PV / rail channels once per tick and qualifies the
// readings into the status flags used by the beacon power FSM.
module beacon_sense_scheduler
  import beacon_pkg::*;
#(
  parameter int unsigned ADC_W      = 12,
  parameter int unsigned SAMPLE_DIV = 1000,
  parameter int unsigned DEBOUNCE   = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             adc_req_o,
  output logic [1:0]       adc_ch_o,
  input  logic             adc_ack_i,
  input  logic [ADC_W-1:0] adc_data_i,
  input  logic [ADC_W-1:0] cap_full_th_i,
  input  logic [ADC_W-1:0] cap_5v_th_i,
  input  logic [ADC_W-1:0] pv_high_th_i,
  input  logic [ADC_W-1:0] pv_low_th_i,
  input  logic [ADC_W-1:0] rail_low_th_i,
  input  logic [ADC_W-1:0] rail_ok_th_i,
  output logic             cap_charged_o,
  output logic             cap_over5_o,
  output logic             pv_power_high_o,
  output logic             low_power_o,
  output logic             scan_done_o,
  output logic             adc_timeout_o
);

  localparam int unsigned TickW = $clog2(SAMPLE_DIV);
  localparam int unsigned WaitW = $clog2(TIMEOUT + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(SAMPLE_DIV - 1);
  // Counter starts in REQ, so adc_req is held for exactly TIMEOUT cycles on expiry.
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;
  state_t           state_q, state_d;
  ch_t              ch_q, ch_d;
  logic             req_q, req_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [ADC_W-1:0] data_q, data_d;
  logic             scan_done_q, scan_done_d;
  logic             timeout_q, timeout_d;
  logic             ack_ok;
  logic             eval_cap, eval_pv, eval_rail;

  assign tick   = (tick_cnt_q == TickLast);
  assign ack_ok = adc_ack_i & req_q;

  // Free-running sample divider.
  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  // Scanner next-state: request, wait for ack or timeout, evaluate, advance channel.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    req_d       = req_q;
    wait_cnt_d  = wait_cnt_q;
    data_d      = data_q;
    scan_done_d = 1'b0;
    timeout_d   = timeout_q;
    case (state_q)
      WAIT_TICK: begin
        if (tick) begin
          state_d    = REQ;
          ch_d       = CH_CAP;
          req_d      = 1'b1;
          wait_cnt_d = '0;
        end
      end
      REQ: begin
        if (ack_ok) begin
          data_d  = adc_data_i;
          req_d   = 1'b0;
          state_d = EVAL;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          state_d    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // An ack coinciding with expiry wins over the timeout.
        if (ack_ok) begin
          data_d  = adc_data_i;
          req_d   = 1'b0;
          state_d = EVAL;
        end else if (wait_cnt_q >= WaitLast) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          state_d   = NEXT;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      EVAL: state_d = NEXT;
      NEXT: begin
        if (ch_q == CH_RAIL) begin
          scan_done_d = 1'b1;
          state_d     = WAIT_TICK;
        end else begin
          ch_d       = ch_q + 2'd1;
          req_d      = 1'b1;
          wait_cnt_d = '0;
          state_d    = REQ;
        end
      end
      default: begin
        state_d = WAIT_TICK;
        req_d   = 1'b0;
      end
    endcase
  end

  // Scanner and divider state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q  <= '0;
      state_q     <= WAIT_TICK;
      ch_q        <= CH_CAP;
      req_q       <= 1'b0;
      wait_cnt_q  <= '0;
      data_q      <= '0;
      scan_done_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      state_q     <= state_d;
      ch_q        <= ch_d;
      req_q       <= req_d;
      wait_cnt_q  <= wait_cnt_d;
      data_q      <= data_d;
      scan_done_q <= scan_done_d;
      timeout_q   <= timeout_d;
    end
  end

  assign eval_cap  = (state_q == EVAL) && (ch_q == CH_CAP);
  assign eval_pv   = (state_q == EVAL) && (ch_q == CH_PV);
  assign eval_rail = (state_q == EVAL) && (ch_q == CH_RAIL);

  beacon_flag_filter #(.ADC_W(ADC_W), .DEBOUNCE(DEBOUNCE), .RESET_VAL(CAP_CHARGED_RST))
  u_cap_charged (
    .clk(clk), .rst_n(rst_n), .en_i(eval_cap), .data_i(data_q),
    .set_th_i(cap_full_th_i), .clr_th_i(cap_full_th_i), .polarity_i(1'b0),
    .flag_o(cap_charged_o)
  );

  beacon_flag_filter #(.ADC_W(ADC_W), .DEBOUNCE(DEBOUNCE), .RESET_VAL(CAP_OVER5_RST))
  u_cap_over5 (
    .clk(clk), .rst_n(rst_n), .en_i(eval_cap), .data_i(data_q),
    .set_th_i(cap_5v_th_i), .clr_th_i(cap_5v_th_i), .polarity_i(1'b0),
    .flag_o(cap_over5_o)
  );

  beacon_flag_filter #(.ADC_W(ADC_W), .DEBOUNCE(DEBOUNCE), .RESET_VAL(PV_HIGH_RST))
  u_pv_high (
    .clk(clk), .rst_n(rst_n), .en_i(eval_pv), .data_i(data_q),
    .set_th_i(pv_high_th_i), .clr_th_i(pv_low_th_i), .polarity_i(1'b0),
    .flag_o(pv_power_high_o)
  );

  beacon_flag_filter #(.ADC_W(ADC_W), .DEBOUNCE(DEBOUNCE), .RESET_VAL(LOW_POWER_RST))
  u_low_power (
    .clk(clk), .rst_n(rst_n), .en_i(eval_rail), .data_i(data_q),
    .set_th_i(rail_low_th_i), .clr_th_i(rail_ok_th_i), .polarity_i(1'b1),
    .flag_o(low_power_o)
  );

  assign adc_req_o     = req_q;
  assign adc_ch_o      = ch_q;
  assign scan_done_o   = scan_done_q;
  assign adc_timeout_o = timeout_q;

endmodule

// File: tb/tb_beacon_sense_scheduler.sv
// Directed bench: a fast-ADC instance (TIMEOUT=16) for flag/timeout scenarios and a
// slow-ADC instance (30-cycle acks, TIMEOUT=40) for tick-dropping behaviour.
module tb_beacon_sense_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] cap_full_th, cap_5v_th, pv_high_th, pv_low_th, rail_low_th, rail_ok_th;

  logic        adc_req, adc_ack, cap_charged, cap_over5, pv_high, low_power, scan_done, adc_timeout;
  logic [1:0]  adc_ch;
  logic [11:0] adc_data;

  logic        adc_req_s, adc_ack_s, cap_charged_s, cap_over5_s, pv_high_s, low_power_s;
  logic        scan_done_s, adc_timeout_s;
  logic [1:0]  adc_ch_s;
  logic [11:0] adc_data_s;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [11:0] ch_data [3];
  int          ack_delay = 2;
  int          mute_ch = -1;
  bit          spur_s = 1'b0;
  int          w_f, w_s;
  bit          seen;
  int          n_ack, cnt, sd1, sd2, r1, r2;
  bit          bad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  beacon_sense_scheduler #(.ADC_W(12), .SAMPLE_DIV(64), .DEBOUNCE(4), .TIMEOUT(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .adc_req_o(adc_req), .adc_ch_o(adc_ch), .adc_ack_i(adc_ack),
    .adc_data_i(adc_data), .cap_full_th_i(cap_full_th), .cap_5v_th_i(cap_5v_th),
    .pv_high_th_i(pv_high_th), .pv_low_th_i(pv_low_th), .rail_low_th_i(rail_low_th),
    .rail_ok_th_i(rail_ok_th), .cap_charged_o(cap_charged), .cap_over5_o(cap_over5),
    .pv_power_high_o(pv_high), .low_power_o(low_power), .scan_done_o(scan_done),
    .adc_timeout_o(adc_timeout)
  );

  beacon_sense_scheduler #(.ADC_W(12), .SAMPLE_DIV(64), .DEBOUNCE(4), .TIMEOUT(40)) u_slow (
    .clk(clk), .rst_n(rst_n), .adc_req_o(adc_req_s), .adc_ch_o(adc_ch_s), .adc_ack_i(adc_ack_s),
    .adc_data_i(adc_data_s), .cap_full_th_i(cap_full_th), .cap_5v_th_i(cap_5v_th),
    .pv_high_th_i(pv_high_th), .pv_low_th_i(pv_low_th), .rail_low_th_i(rail_low_th),
    .rail_ok_th_i(rail_ok_th), .cap_charged_o(cap_charged_s), .cap_over5_o(cap_over5_s),
    .pv_power_high_o(pv_high_s), .low_power_o(low_power_s), .scan_done_o(scan_done_s),
    .adc_timeout_o(adc_timeout_s)
  );

  // Fast ADC model: acks on the ack_delay-th cycle of a request unless the channel is muted.
  initial begin
    adc_ack = 1'b0; adc_data = '0; w_f = 0;
    forever begin
      @(negedge clk);
      adc_ack = 1'b0;
      if (adc_req === 1'b1) begin
        w_f++;
        if (w_f == ack_delay && int'(adc_ch) != mute_ch) begin
          adc_ack  = 1'b1;
          adc_data = ch_data[adc_ch];
        end
      end else begin
        w_f = 0;
      end
    end
  end

  // Slow ADC model: 30-cycle acks, plus optional spurious acks while idle.
  initial begin
    adc_ack_s = 1'b0; adc_data_s = '0; w_s = 0;
    forever begin
      @(negedge clk);
      adc_ack_s = 1'b0;
      if (adc_req_s === 1'b1) begin
        w_s++;
        if (w_s == 30) begin
          adc_ack_s  = 1'b1;
          adc_data_s = (adc_ch_s == 2'd2) ? 12'h100 : 12'h000;
        end
      end else begin
        w_s = 0;
        if (spur_s) begin
          adc_ack_s  = 1'b1;
          adc_data_s = 12'hFFF;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_scan_done(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (scan_done === 1'b1) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_scan_done_s(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (scan_done_s === 1'b1) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_req_ch(input logic [1:0] ch, input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (adc_req === 1'b1 && adc_ch === ch) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_ack_ch(input logic [1:0] ch, input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (adc_ack === 1'b1 && adc_ch === ch) begin found = 1'b1; break; end
    end
  endtask

  task automatic wait_req_s(input int max_cyc, output bit found);
    found = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (adc_req_s === 1'b1) begin found = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++; if (adc_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", adc_req); end
    checks++; if (adc_ch !== 2'd0) begin errors++; $display("FAIL rst_ch: got %0d want 0", adc_ch); end
    checks++;
    if ({cap_charged, cap_over5, pv_high} !== 3'b000) begin
      errors++; $display("FAIL rst_flags: got %b want 000", {cap_charged, cap_over5, pv_high});
    end
    checks++; if (low_power !== 1'b1) begin errors++; $display("FAIL rst_low_power: got %b want 1", low_power); end
    checks++;
    if ({scan_done, adc_timeout} !== 2'b00) begin
      errors++; $display("FAIL rst_done_timeout: got %b want 00", {scan_done, adc_timeout});
    end
    // Hold the fast ADC silent so reset lands while the request is pending.
    ack_delay = 100;
    @(negedge clk); rst_n = 1'b1;
    wait_req_ch(2'd0, 200, seen);
    checks++; if (!seen) begin errors++; $display("FAIL rst_first_req: got none want req within 200"); end
    repeat (3) step();
    checks++; if (adc_req !== 1'b1) begin errors++; $display("FAIL rst_pending_req: got %b want 1", adc_req); end
    #1; rst_n = 1'b0; #1;
    checks++; if (adc_req !== 1'b0) begin errors++; $display("FAIL async_rst_req: got %b want 0", adc_req); end
    checks++; if (low_power !== 1'b1) begin errors++; $display("FAIL async_rst_low_power: got %b want 1", low_power); end
    checks++;
    if ({cap_charged, cap_over5, pv_high, adc_timeout} !== 4'b0000) begin
      errors++; $display("FAIL async_rst_flags: got %b want 0000", {cap_charged, cap_over5, pv_high, adc_timeout});
    end
    repeat (2) step();
    ack_delay = 2;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_cap_debounce();
    for (int s = 1; s <= 3; s++) begin
      wait_scan_done(200, seen);
      checks++; if (!seen) begin errors++; $display("FAIL cap_scan%0d_done: got none want pulse", s); end
      checks++;
      if (cap_charged !== 1'b0) begin errors++; $display("FAIL cap_scan%0d: got %b want 0", s, cap_charged); end
    end
    wait_ack_ch(2'd0, 200, seen);
    checks++; if (!seen) begin errors++; $display("FAIL cap_ack4: got none want ack"); end
    n_ack = cyc;
    step();
    checks++;
    if (cap_charged !== 1'b0) begin errors++; $display("FAIL cap_ack_plus1: got %b want 0", cap_charged); end
    step();
    checks++;
    if (cap_charged !== 1'b1 || cyc != n_ack + 2) begin
      errors++; $display("FAIL cap_ack_plus2: got %b at +%0d want 1 at +2", cap_charged, cyc - n_ack);
    end
    checks++; if (cap_over5 !== 1'b1) begin errors++; $display("FAIL cap_over5: got %b want 1", cap_over5); end
    wait_scan_done(50, seen);
    checks++;
    if (!seen || low_power !== 1'b0) begin
      errors++; $display("FAIL rail_ok_after4: got done=%b lp=%b want 1 0", seen, low_power);
    end
  endtask

  task automatic test_pv_hysteresis();
    ch_data[1] = 12'h900;
    for (int s = 1; s <= 4; s++) begin
      wait_scan_done(200, seen);
      checks++;
      if (!seen || pv_high !== (s == 4)) begin
        errors++; $display("FAIL pv_rise_scan%0d: got %b want %b", s, pv_high, (s == 4));
      end
    end
    ch_data[1] = 12'h700;
    for (int s = 1; s <= 6; s++) begin
      wait_scan_done(200, seen);
      checks++;
      if (!seen || pv_high !== 1'b1) begin errors++; $display("FAIL pv_hold_scan%0d: got %b want 1", s, pv_high); end
    end
    ch_data[1] = 12'h500;
    for (int s = 1; s <= 4; s++) begin
      wait_scan_done(200, seen);
      checks++;
      if (!seen || pv_high !== (s < 4)) begin
        errors++; $display("FAIL pv_fall_scan%0d: got %b want %b", s, pv_high, (s < 4));
      end
    end
  endtask

  task automatic test_rail_alternate();
    for (int s = 0; s < 8; s++) begin
      ch_data[2] = (s % 2 == 0) ? 12'h100 : 12'h300;
      wait_scan_done(200, seen);
      checks++;
      if (!seen || low_power !== 1'b0) begin errors++; $display("FAIL rail_alt_scan%0d: got %b want 0", s, low_power); end
    end
    ch_data[2] = 12'h300;
  endtask

  task automatic test_timeout();
    checks++; if (adc_timeout !== 1'b0) begin errors++; $display("FAIL timeout_pre: got %b want 0", adc_timeout); end
    mute_ch = 1;
    ch_data[1] = 12'h900;
    for (int s = 0; s < 4; s++) begin
      wait_req_ch(2'd1, 200, seen);
      checks++; if (!seen) begin errors++; $display("FAIL to_req_ch1_%0d: got none want req", s); end
      cnt = 1;
      for (int i = 0; i < 100; i++) begin
        step();
        if (adc_req !== 1'b1) break;
        cnt++;
      end
      checks++; if (cnt != 16) begin errors++; $display("FAIL to_req_len_%0d: got %0d want 16", s, cnt); end
      checks++; if (adc_timeout !== 1'b1) begin errors++; $display("FAIL to_sticky_%0d: got %b want 1", s, adc_timeout); end
      wait_req_ch(2'd2, 50, seen);
      checks++; if (!seen) begin errors++; $display("FAIL to_req_ch2_%0d: got none want req", s); end
      wait_scan_done(50, seen);
      checks++; if (!seen) begin errors++; $display("FAIL to_scan_done_%0d: got none want pulse", s); end
    end
    checks++; if (pv_high !== 1'b0) begin errors++; $display("FAIL to_pv_unchanged: got %b want 0", pv_high); end
    mute_ch = -1;
    wait_scan_done(200, seen);
    checks++;
    if (!seen || adc_timeout !== 1'b1) begin
      errors++; $display("FAIL to_sticky_after: got done=%b to=%b want 1 1", seen, adc_timeout);
    end
  endtask

  task automatic test_slow_adc();
    checks++; if (adc_timeout_s !== 1'b0) begin errors++; $display("FAIL slow_timeout: got %b want 0", adc_timeout_s); end
    wait_scan_done_s(400, seen);
    checks++; if (!seen) begin errors++; $display("FAIL slow_done1: got none want pulse"); end
    step();
    checks++; if (adc_req_s !== 1'b0) begin errors++; $display("FAIL slow_no_restart: got %b want 0", adc_req_s); end
    spur_s = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      step();
      if (adc_req_s !== 1'b0 || scan_done_s !== 1'b0) bad = 1'b1;
    end
    spur_s = 1'b0;
    checks++; if (bad) begin errors++; $display("FAIL slow_spurious_ack: got activity want idle"); end
    wait_req_s(200, seen);
    r1 = cyc;
    checks++; if (!seen) begin errors++; $display("FAIL slow_req1: got none want req"); end
    wait_scan_done_s(200, seen);
    sd2 = cyc;
    checks++;
    if (!seen || sd2 - r1 != 96) begin errors++; $display("FAIL slow_scan_len: got %0d want 96", sd2 - r1); end
    wait_req_s(200, seen);
    r2 = cyc;
    checks++;
    if (!seen || r2 - r1 != 128) begin errors++; $display("FAIL slow_scan_period: got %0d want 128", r2 - r1); end
    checks++;
    if (low_power_s !== 1'b1 || cap_charged_s !== 1'b0) begin
      errors++; $display("FAIL slow_flags: got lp=%b cc=%b want 1 0", low_power_s, cap_charged_s);
    end
  endtask

  initial begin
    cap_full_th = 12'hE00; cap_5v_th = 12'hA00;
    pv_high_th  = 12'h800; pv_low_th = 12'h600;
    rail_low_th = 12'h200; rail_ok_th = 12'h280;
    ch_data[0] = 12'hF00; ch_data[1] = 12'h000; ch_data[2] = 12'h300;
    test_reset();
    test_cap_debounce();
    test_pv_hysteresis();
    test_rail_alternate();
    test_timeout();
    test_slow_adc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
